// File: rtl/id_ex_if.sv
// id_ex_if: decode-stage instruction, forwarding sources and EX-stage outputs of the ID/EX stage.
interface id_ex_if #(parameter int DATA_W = 32, parameter int RA_W = 5, parameter int CNT_W = 16);
   logic              id_valid;
   logic [RA_W-1:0]   id_rs1;
   logic [RA_W-1:0]   id_rs2;
   logic [RA_W-1:0]   id_rd;
   logic [DATA_W-1:0] id_rs1_data;
   logic [DATA_W-1:0] id_rs2_data;
   logic [DATA_W-1:0] id_imm;
   logic              id_use_imm;
   logic [3:0]        id_func;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              id_mem_write;
   logic              flush;
   logic              mem_fwd_en;
   logic [RA_W-1:0]   mem_fwd_rd;
   logic [DATA_W-1:0] mem_fwd_data;
   logic              wb_fwd_en;
   logic [RA_W-1:0]   wb_fwd_rd;
   logic [DATA_W-1:0] wb_fwd_data;
   logic              stall_id;
   logic [DATA_W-1:0] alu_in1;
   logic [DATA_W-1:0] alu_in2;
   logic [3:0]        alu_func;
   logic              ex_valid;
   logic [RA_W-1:0]   ex_rd;
   logic              ex_reg_write;
   logic              ex_mem_read;
   logic              ex_mem_write;
   logic [DATA_W-1:0] ex_store_data;
   logic [CNT_W-1:0]  stall_count;
   modport master (
      output id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_use_imm,
             id_func, id_reg_write, id_mem_read, id_mem_write, flush,
             mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data,
      input  stall_id, alu_in1, alu_in2, alu_func, ex_valid, ex_rd, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_store_data, stall_count
   );
   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm, id_use_imm,
             id_func, id_reg_write, id_mem_read, id_mem_write, flush,
             mem_fwd_en, mem_fwd_rd, mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data,
      output stall_id, alu_in1, alu_in2, alu_func, ex_valid, ex_rd, ex_reg_write,
             ex_mem_read, ex_mem_write, ex_store_data, stall_count
   );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB forwarding, load-use bubbles and stall counting.
module id_ex_stage #(parameter int DATA_W = 32, parameter int RA_W = 5, parameter int CNT_W = 16) (
   input logic    clk,
   input logic    rst,
   id_ex_if.slave bus
);
   logic              r_valid, r_use_imm, r_reg_write, r_mem_read, r_mem_write;
   logic [RA_W-1:0]   r_rd, r_rs1, r_rs2;
   logic [DATA_W-1:0] r_rs1_data, r_rs2_data, r_imm;
   logic [3:0]        r_func;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_luh, w_stall, w_kill, w_cap;
   logic [DATA_W-1:0] w_rs1_fwd, w_rs2_fwd;
   // rs2 only matters to a load when it feeds the ALU or supplies store data
   assign w_luh = r_valid && r_mem_read && r_rd != '0 && bus.id_valid &&
                  (r_rd == bus.id_rs1 || (r_rd == bus.id_rs2 && (!bus.id_use_imm || bus.id_mem_write)));
   assign w_stall = w_luh && !bus.flush;
   assign w_kill  = bus.flush || w_luh;
   assign w_cap   = !w_kill && bus.id_valid;
   assign w_rs1_fwd = (bus.mem_fwd_en && bus.mem_fwd_rd == r_rs1 && r_rs1 != '0) ? bus.mem_fwd_data :
                      (bus.wb_fwd_en && bus.wb_fwd_rd == r_rs1 && r_rs1 != '0) ? bus.wb_fwd_data : r_rs1_data;
   assign w_rs2_fwd = (bus.mem_fwd_en && bus.mem_fwd_rd == r_rs2 && r_rs2 != '0) ? bus.mem_fwd_data :
                      (bus.wb_fwd_en && bus.wb_fwd_rd == r_rs2 && r_rs2 != '0) ? bus.wb_fwd_data : r_rs2_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_use_imm   <= 1'b0;
         r_reg_write <= 1'b0;
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
         r_rs1_data  <= '0;
         r_rs2_data  <= '0;
         r_imm       <= '0;
         r_func      <= '0;
         r_cnt       <= '0;
      end else begin
         r_valid     <= w_cap;
         r_use_imm   <= w_kill ? 1'b0 : bus.id_use_imm;
         r_reg_write <= w_cap && bus.id_reg_write;
         r_mem_read  <= w_cap && bus.id_mem_read;
         r_mem_write <= w_cap && bus.id_mem_write;
         r_rd        <= w_kill ? '0 : bus.id_rd;
         r_rs1       <= w_kill ? '0 : bus.id_rs1;
         r_rs2       <= w_kill ? '0 : bus.id_rs2;
         r_rs1_data  <= w_kill ? '0 : bus.id_rs1_data;
         r_rs2_data  <= w_kill ? '0 : bus.id_rs2_data;
         r_imm       <= w_kill ? '0 : bus.id_imm;
         r_func      <= w_kill ? '0 : bus.id_func;
         r_cnt       <= (w_stall && !(&r_cnt)) ? r_cnt + CNT_W'(1) : r_cnt;
      end
   end
   assign bus.stall_id      = w_stall;
   assign bus.alu_in1       = w_rs1_fwd;
   assign bus.alu_in2       = r_use_imm ? r_imm : w_rs2_fwd;
   assign bus.alu_func      = r_func;
   assign bus.ex_valid      = r_valid;
   assign bus.ex_rd         = r_rd;
   assign bus.ex_reg_write  = r_reg_write;
   assign bus.ex_mem_read   = r_mem_read;
   assign bus.ex_mem_write  = r_mem_write;
   assign bus.ex_store_data = w_rs2_fwd;
   assign bus.stall_count   = r_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of capture, forwarding, load-use stalls, flush and counter saturation.
module tb_id_ex_stage;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;
   id_ex_if #(.DATA_W(32), .RA_W(5), .CNT_W(16)) bus ();
   id_ex_if #(.DATA_W(32), .RA_W(5), .CNT_W(2))  sbus ();
   id_ex_stage #(.DATA_W(32), .RA_W(5), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
   id_ex_stage #(.DATA_W(32), .RA_W(5), .CNT_W(2))  sdut (.clk(clk), .rst(rst), .bus(sbus));
   always #5 clk = ~clk;
   // the narrow-counter instance sees exactly the same stimulus
   assign sbus.id_valid     = bus.id_valid;
   assign sbus.id_rs1       = bus.id_rs1;
   assign sbus.id_rs2       = bus.id_rs2;
   assign sbus.id_rd        = bus.id_rd;
   assign sbus.id_rs1_data  = bus.id_rs1_data;
   assign sbus.id_rs2_data  = bus.id_rs2_data;
   assign sbus.id_imm       = bus.id_imm;
   assign sbus.id_use_imm   = bus.id_use_imm;
   assign sbus.id_func      = bus.id_func;
   assign sbus.id_reg_write = bus.id_reg_write;
   assign sbus.id_mem_read  = bus.id_mem_read;
   assign sbus.id_mem_write = bus.id_mem_write;
   assign sbus.flush        = bus.flush;
   assign sbus.mem_fwd_en   = bus.mem_fwd_en;
   assign sbus.mem_fwd_rd   = bus.mem_fwd_rd;
   assign sbus.mem_fwd_data = bus.mem_fwd_data;
   assign sbus.wb_fwd_en    = bus.wb_fwd_en;
   assign sbus.wb_fwd_rd    = bus.wb_fwd_rd;
   assign sbus.wb_fwd_data  = bus.wb_fwd_data;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
      bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_use_imm = 0;
      bus.id_func = 0; bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
      bus.flush = 0; bus.mem_fwd_en = 0; bus.mem_fwd_rd = 0; bus.mem_fwd_data = 0;
      bus.wb_fwd_en = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 0;
   endtask

   task automatic load_rd4();
      idle();
      bus.id_valid = 1; bus.id_rd = 4; bus.id_mem_read = 1; bus.id_reg_write = 1; bus.id_rs1 = 9;
      step();
   endtask

   task automatic test_reset();
      bus.id_valid = 1; bus.id_rs1 = 5'($urandom); bus.id_rs2 = 5'($urandom); bus.id_rd = 5'($urandom);
      bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
      bus.id_use_imm = 1'($urandom); bus.id_func = 4'($urandom); bus.id_reg_write = 1;
      bus.id_mem_read = 1; bus.id_mem_write = 1; bus.flush = 0;
      bus.mem_fwd_en = 1; bus.mem_fwd_rd = 5'($urandom); bus.mem_fwd_data = $urandom;
      bus.wb_fwd_en = 1; bus.wb_fwd_rd = 5'($urandom); bus.wb_fwd_data = $urandom;
      rst = 1;
      step();
      step();
      n_vec++; if (bus.alu_in1 !== 0) begin $display("FAIL reset alu_in1 got %h exp 0", bus.alu_in1); n_err++; end
      n_vec++; if (bus.alu_in2 !== 0) begin $display("FAIL reset alu_in2 got %h exp 0", bus.alu_in2); n_err++; end
      n_vec++; if (bus.alu_func !== 0) begin $display("FAIL reset alu_func got %h exp 0", bus.alu_func); n_err++; end
      n_vec++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== 4'b0)
         begin $display("FAIL reset ex_ctrl got %b exp 0000", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}); n_err++; end
      n_vec++; if (bus.ex_rd !== 0) begin $display("FAIL reset ex_rd got %h exp 0", bus.ex_rd); n_err++; end
      n_vec++; if (bus.ex_store_data !== 0) begin $display("FAIL reset store_data got %h exp 0", bus.ex_store_data); n_err++; end
      n_vec++; if (bus.stall_id !== 0) begin $display("FAIL reset stall_id got %b exp 0", bus.stall_id); n_err++; end
      n_vec++; if (bus.stall_count !== 0) begin $display("FAIL reset stall_count got %0d exp 0", bus.stall_count); n_err++; end
      n_vec++; if (sbus.stall_count !== 0) begin $display("FAIL reset small_count got %0d exp 0", sbus.stall_count); n_err++; end
      idle();
      rst = 0;
   endtask

   task automatic test_pipeline();
      idle();
      bus.id_valid = 1; bus.id_rs1 = 1; bus.id_rs1_data = 5; bus.id_rs2 = 2; bus.id_rs2_data = 7;
      bus.id_func = 4'b0100; bus.id_rd = 6; bus.id_reg_write = 1;
      step();
      idle();
      n_vec++; if (bus.alu_in1 !== 5) begin $display("FAIL pipe alu_in1 got %h exp 5", bus.alu_in1); n_err++; end
      n_vec++; if (bus.alu_in2 !== 7) begin $display("FAIL pipe alu_in2 got %h exp 7", bus.alu_in2); n_err++; end
      n_vec++; if (bus.alu_func !== 4'b0100) begin $display("FAIL pipe alu_func got %b exp 0100", bus.alu_func); n_err++; end
      n_vec++; if (bus.ex_valid !== 1) begin $display("FAIL pipe ex_valid got %b exp 1", bus.ex_valid); n_err++; end
      n_vec++; if (bus.ex_rd !== 6) begin $display("FAIL pipe ex_rd got %h exp 6", bus.ex_rd); n_err++; end
      n_vec++; if (bus.ex_reg_write !== 1) begin $display("FAIL pipe reg_write got %b exp 1", bus.ex_reg_write); n_err++; end
      bus.id_valid = 1; bus.id_rs2 = 2; bus.id_rs2_data = 7; bus.id_imm = 32'h100; bus.id_use_imm = 1;
      bus.id_func = 4'b1100;
      step();
      idle();
      n_vec++; if (bus.alu_in2 !== 32'h100) begin $display("FAIL imm alu_in2 got %h exp 100", bus.alu_in2); n_err++; end
      n_vec++; if (bus.ex_store_data !== 7) begin $display("FAIL imm store_data got %h exp 7", bus.ex_store_data); n_err++; end
      n_vec++; if (bus.alu_func !== 4'b1100) begin $display("FAIL imm alu_func got %b exp 1100", bus.alu_func); n_err++; end
      bus.id_valid = 0; bus.id_reg_write = 1; bus.id_mem_write = 1; bus.id_rd = 3;
      step();
      idle();
      n_vec++; if ({bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write} !== 3'b0)
         begin $display("FAIL invalid ctrl got %b exp 000", {bus.ex_valid, bus.ex_reg_write, bus.ex_mem_write}); n_err++; end
   endtask

   task automatic test_forwarding();
      idle();
      bus.id_valid = 1; bus.id_rs1 = 3; bus.id_rs1_data = 32'h11; bus.id_rs2 = 3; bus.id_rs2_data = 32'h22;
      bus.id_use_imm = 1; bus.id_imm = 9;
      step();
      idle();
      bus.mem_fwd_en = 1; bus.mem_fwd_rd = 3; bus.mem_fwd_data = 32'hAA;
      bus.wb_fwd_en = 1; bus.wb_fwd_rd = 3; bus.wb_fwd_data = 32'hBB;
      #1;
      n_vec++; if (bus.alu_in1 !== 32'hAA) begin $display("FAIL fwd_mem alu_in1 got %h exp aa", bus.alu_in1); n_err++; end
      n_vec++; if (bus.ex_store_data !== 32'hAA) begin $display("FAIL fwd_mem store got %h exp aa", bus.ex_store_data); n_err++; end
      n_vec++; if (bus.alu_in2 !== 9) begin $display("FAIL fwd_imm alu_in2 got %h exp 9", bus.alu_in2); n_err++; end
      bus.mem_fwd_en = 0;
      #1;
      n_vec++; if (bus.alu_in1 !== 32'hBB) begin $display("FAIL fwd_wb alu_in1 got %h exp bb", bus.alu_in1); n_err++; end
      bus.wb_fwd_rd = 7;
      #1;
      n_vec++; if (bus.alu_in1 !== 32'h11) begin $display("FAIL fwd_none alu_in1 got %h exp 11", bus.alu_in1); n_err++; end
      idle();
      bus.id_valid = 1; bus.id_rs1 = 0; bus.id_rs1_data = 0;
      step();
      idle();
      bus.mem_fwd_en = 1; bus.mem_fwd_rd = 0; bus.mem_fwd_data = 32'hAA;
      bus.wb_fwd_en = 1; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 32'hBB;
      #1;
      n_vec++; if (bus.alu_in1 !== 0) begin $display("FAIL fwd_x0 alu_in1 got %h exp 0", bus.alu_in1); n_err++; end
      idle();
   endtask

   task automatic test_load_use();
      load_rd4();
      idle();
      bus.id_valid = 1; bus.id_rs1 = 7; bus.id_rs2 = 4; bus.id_use_imm = 0;
      #1;
      n_vec++; if (bus.stall_id !== 1) begin $display("FAIL luh stall_id got %b exp 1", bus.stall_id); n_err++; end
      step();
      n_vec++; if (bus.ex_valid !== 0) begin $display("FAIL luh bubble ex_valid got %b exp 0", bus.ex_valid); n_err++; end
      n_vec++; if (bus.ex_mem_read !== 0) begin $display("FAIL luh bubble mem_read got %b exp 0", bus.ex_mem_read); n_err++; end
      n_vec++; if (bus.stall_count !== 1) begin $display("FAIL luh stall_count got %0d exp 1", bus.stall_count); n_err++; end
      load_rd4();
      idle();
      bus.id_valid = 1; bus.id_rs1 = 7; bus.id_rs2 = 4; bus.id_use_imm = 1; bus.id_mem_write = 0;
      #1;
      n_vec++; if (bus.stall_id !== 0) begin $display("FAIL imm_nostall stall_id got %b exp 0", bus.stall_id); n_err++; end
      step();
      n_vec++; if (bus.ex_valid !== 1) begin $display("FAIL imm_nostall ex_valid got %b exp 1", bus.ex_valid); n_err++; end
      n_vec++; if (bus.stall_count !== 1) begin $display("FAIL imm_nostall count got %0d exp 1", bus.stall_count); n_err++; end
      load_rd4();
      idle();
      bus.id_valid = 1; bus.id_rs2 = 4; bus.id_use_imm = 1; bus.id_mem_write = 1;
      #1;
      n_vec++; if (bus.stall_id !== 1) begin $display("FAIL store_data stall_id got %b exp 1", bus.stall_id); n_err++; end
      step();
      n_vec++; if (bus.stall_count !== 2) begin $display("FAIL store_data count got %0d exp 2", bus.stall_count); n_err++; end
      idle();
   endtask

   task automatic test_flush();
      load_rd4();
      idle();
      bus.id_valid = 1; bus.id_rs1 = 4; bus.flush = 1; bus.id_reg_write = 1;
      #1;
      n_vec++; if (bus.stall_id !== 0) begin $display("FAIL flush stall_id got %b exp 0", bus.stall_id); n_err++; end
      step();
      n_vec++; if (bus.ex_valid !== 0) begin $display("FAIL flush ex_valid got %b exp 0", bus.ex_valid); n_err++; end
      n_vec++; if (bus.ex_reg_write !== 0) begin $display("FAIL flush reg_write got %b exp 0", bus.ex_reg_write); n_err++; end
      n_vec++; if (bus.stall_count !== 2) begin $display("FAIL flush stall_count got %0d exp 2", bus.stall_count); n_err++; end
      idle();
   endtask

   task automatic test_saturation();
      rst = 1;
      step();
      rst = 0;
      idle();
      bus.id_valid = 1; bus.id_rd = 4; bus.id_rs1 = 4; bus.id_mem_read = 1; bus.id_reg_write = 1;
      for (int i = 0; i < 10; i++) step();
      n_vec++; if (bus.stall_count !== 5) begin $display("FAIL sat wide_count got %0d exp 5", bus.stall_count); n_err++; end
      n_vec++; if (sbus.stall_count !== 3) begin $display("FAIL sat small_count got %0d exp 3", sbus.stall_count); n_err++; end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_pipeline();
      test_forwarding();
      test_load_use();
      test_flush();
      test_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
